// File: rtl/csi_frame_writer_if.sv
// Bus between the raw8 unpacker / CSI packet decoder and the frame-buffer write port.
interface csi_frame_writer_if #(
    parameter int ADDR_W = 19
);
    logic [31:0]       raw;
    logic              raw_valid;
    logic              frame_start;
    logic              frame_end;
    logic              cam_sel;
    logic [7:0]        pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_we_cam0;
    logic              pix_we_cam1;
    logic              frame_done;
    logic              short_frame;
    logic              overflow;

    modport slave (
        input  raw, raw_valid, frame_start, frame_end,
        output cam_sel, pix_data, pix_addr, pix_we_cam0, pix_we_cam1,
               frame_done, short_frame, overflow
    );

    modport master (
        output raw, raw_valid, frame_start, frame_end,
        input  cam_sel, pix_data, pix_addr, pix_we_cam0, pix_we_cam1,
               frame_done, short_frame, overflow
    );
endinterface

// File: rtl/csi_frame_writer.sv
// CSI raw8 frame writer: buffers 32-bit raw words in a 2-entry FIFO, serialises
// them to one pixel per clock and writes linear addresses into the selected
// camera buffer. Optional macro ALTERNATE_CAM_EN enables cam0/cam1 ping-pong.
module csi_frame_writer #(
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W       = 19,
    parameter int FIFO_DEPTH   = 2
) (
    input logic               clk,
    input logic               rst,
    csi_frame_writer_if.slave bus
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_SWITCH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [31:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [31:0]       ser_word_q, ser_word_d;
    logic [1:0]        ser_idx_q, ser_idx_d;
    logic              ser_valid_q, ser_valid_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;

    logic              cam_sel_q, cam_sel_d;
    logic [7:0]        pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              we0_q, we0_d, we1_q, we1_d;
    logic              frame_done_q, frame_done_d;
    logic              short_q, short_d;
    logic              ovf_q, ovf_d;

    logic restart, draining, pop, push_req, push, drop, emit, in_range, wr;

    // frame_end takes priority over frame_start while ACTIVE
    assign restart  = bus.frame_start &&
                      ((state_q == S_IDLE) || (state_q == S_ACTIVE && !bus.frame_end));
    assign draining = (state_q == S_ACTIVE) || (state_q == S_FLUSH);
    assign pop      = draining && (fifo_cnt_q != '0) && (!ser_valid_q || ser_idx_q == 2'd3);
    assign push_req = (state_q == S_ACTIVE) && bus.raw_valid;
    assign push     = push_req && ((fifo_cnt_q != FCNT_W'(FIFO_DEPTH)) || pop);
    assign drop     = push_req && !push;
    assign emit     = draining && ser_valid_q;
    assign in_range = pix_cnt_q < CNT_W'(FRAME_PIXELS);
    assign wr       = !restart && emit && in_range;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.frame_start) state_d = S_ACTIVE;
            S_ACTIVE: if (bus.frame_end) state_d = S_FLUSH;
            S_FLUSH:  if (fifo_cnt_q == '0 && !ser_valid_q) state_d = S_SWITCH;
            S_SWITCH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FIFO, serialiser and pixel counter update
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        ser_word_d  = ser_word_q;
        ser_idx_d   = ser_idx_q;
        ser_valid_d = ser_valid_q;
        pix_cnt_d   = pix_cnt_q;
        if (restart) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
            ser_idx_d   = '0;
            ser_valid_d = 1'b0;
            pix_cnt_d   = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = bus.raw;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            fifo_cnt_d = fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
            if (emit) begin
                ser_idx_d = ser_idx_q + 2'd1;
                if (ser_idx_q == 2'd3) ser_valid_d = 1'b0;
                // counter saturates at FRAME_PIXELS: excess pixels are consumed unwritten
                if (in_range) pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
            // a pop on byte 3 reloads the serialiser back-to-back
            if (pop) begin
                ser_word_d  = fifo_q[rd_ptr_q];
                ser_idx_d   = '0;
                ser_valid_d = 1'b1;
            end
        end
    end

    // FSM / datapath output logic feeding the registered outputs
    always_comb begin
        pix_data_d   = wr ? ser_word_q[{ser_idx_q, 3'b000} +: 8] : '0;
        pix_addr_d   = wr ? pix_cnt_q[ADDR_W-1:0] : '0;
        frame_done_d = (state_d == S_SWITCH);
        short_d      = (state_d == S_SWITCH) && (pix_cnt_q != CNT_W'(FRAME_PIXELS));
        ovf_d        = restart ? 1'b0 : (drop ? 1'b1 : ovf_q);
`ifdef ALTERNATE_CAM_EN
        cam_sel_d = (state_q == S_SWITCH && pix_cnt_q == CNT_W'(FRAME_PIXELS)) ? ~cam_sel_q
                                                                              : cam_sel_q;
        we0_d     = wr && !cam_sel_q;
        we1_d     = wr && cam_sel_q;
`else
        cam_sel_d = 1'b0;
        we0_d     = wr;
        we1_d     = 1'b0;
`endif
    end

    // datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            ser_word_q   <= '0;
            ser_idx_q    <= '0;
            ser_valid_q  <= 1'b0;
            pix_cnt_q    <= '0;
            cam_sel_q    <= 1'b0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            we0_q        <= 1'b0;
            we1_q        <= 1'b0;
            frame_done_q <= 1'b0;
            short_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            ser_word_q   <= ser_word_d;
            ser_idx_q    <= ser_idx_d;
            ser_valid_q  <= ser_valid_d;
            pix_cnt_q    <= pix_cnt_d;
            cam_sel_q    <= cam_sel_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            we0_q        <= we0_d;
            we1_q        <= we1_d;
            frame_done_q <= frame_done_d;
            short_q      <= short_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.cam_sel     = cam_sel_q;
    assign bus.pix_data    = pix_data_q;
    assign bus.pix_addr    = pix_addr_q;
    assign bus.pix_we_cam0 = we0_q;
    assign bus.pix_we_cam1 = we1_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.short_frame = short_q;
    assign bus.overflow    = ovf_q;
endmodule
